// File: rtl/alu_pkg.sv
// rtl/alu_pkg.sv - opcode constants and data width for the execute-stage ALU
// Contents: WIDTH (data width), OP_* operation codes for the 4-bit control input.
package alu_pkg;

  localparam int WIDTH = 32;

  localparam logic [3:0] OP_ADD  = 4'd0;
  localparam logic [3:0] OP_SUB  = 4'd1;
  localparam logic [3:0] OP_AND  = 4'd2;
  localparam logic [3:0] OP_OR   = 4'd3;
  localparam logic [3:0] OP_XOR  = 4'd4;
  localparam logic [3:0] OP_NOR  = 4'd5;
  localparam logic [3:0] OP_SLL  = 4'd6;
  localparam logic [3:0] OP_SRL  = 4'd7;
  localparam logic [3:0] OP_SRA  = 4'd8;
  localparam logic [3:0] OP_SLT  = 4'd9;
  localparam logic [3:0] OP_SLTU = 4'd10;
  localparam logic [3:0] OP_MUL  = 4'd11;

endpackage

// File: rtl/alu_addsub.sv
// rtl/alu_addsub.sv - 32-bit adder with optional B inversion and carry-in
// Ports: a, b (operands), sub (1 = compute a + ~b + 1),
//        sum (low 32 bits), carry (bit 32 of the sum), overflow (signed overflow).
module alu_addsub
  import alu_pkg::*;
(
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             sub,
  output logic [WIDTH-1:0] sum,
  output logic             carry,
  output logic             overflow
);

  logic [WIDTH-1:0] b_eff;

  assign b_eff = sub ? ~b : b;
  assign {carry, sum} = {1'b0, a} + {1'b0, b_eff} + {{WIDTH{1'b0}}, sub};
  // Signs of the actual addends agree but the result sign differs.
  assign overflow = (a[WIDTH-1] == b_eff[WIDTH-1]) && (sum[WIDTH-1] != a[WIDTH-1]);

endmodule

// File: rtl/alu_main.sv
// rtl/alu_main.sv - registered 32-bit integer ALU (execute stage), one-cycle latency
// Ports: clk, rst (sync active-high), A, B, control (opcode) in;
//        S, carry, overflow, lessthan, equalto, zero registered out.
// Build option: define ALU_MUL_EN to implement opcode 11 as the low 32 bits of A*B;
//        otherwise opcode 11 is reserved and no multiplier exists.
module alu_main
  import alu_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic [3:0]       control,
  output logic [WIDTH-1:0] S,
  output logic             carry,
  output logic             overflow,
  output logic             lessthan,
  output logic             equalto,
  output logic             zero
);

  logic [WIDTH-1:0] add_sum;
  logic             add_carry;
  logic             add_ovf;
  logic             add_sub;
  logic [4:0]       shamt;
  logic [WIDTH-1:0] s_c;
  logic             carry_c;
  logic             ovf_c;
  logic             lt_c;
  logic             eq_c;

  // Only ADD uses the true sum; SUB, SLT and SLTU all need A - B.
  assign add_sub = (control != OP_ADD);
  assign shamt   = B[4:0];

  alu_addsub u_addsub (
    .a        (A),
    .b        (B),
    .sub      (add_sub),
    .sum      (add_sum),
    .carry    (add_carry),
    .overflow (add_ovf)
  );

  assign lt_c = ($signed(A) < $signed(B));
  assign eq_c = (A == B);

  always_comb begin
    s_c     = '0;
    carry_c = 1'b0;
    ovf_c   = 1'b0;
    case (control)
      OP_ADD, OP_SUB: begin
        s_c     = add_sum;
        carry_c = add_carry;
        ovf_c   = add_ovf;
      end
      OP_AND:  s_c = A & B;
      OP_OR:   s_c = A | B;
      OP_XOR:  s_c = A ^ B;
      OP_NOR:  s_c = ~(A | B);
      OP_SLL:  s_c = A << shamt;
      OP_SRL:  s_c = A >> shamt;
      OP_SRA:  s_c = $unsigned($signed(A) >>> shamt);
      // Signed less-than from A - B: sign of the difference corrected by overflow.
      OP_SLT:  s_c = {{(WIDTH-1){1'b0}}, add_sum[WIDTH-1] ^ add_ovf};
      // Unsigned less-than: a borrow (no carry-out) means A < B.
      OP_SLTU: s_c = {{(WIDTH-1){1'b0}}, ~add_carry};
`ifdef ALU_MUL_EN
      OP_MUL:  s_c = A * B;
`endif
      default: s_c = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      S        <= '0;
      carry    <= 1'b0;
      overflow <= 1'b0;
      lessthan <= 1'b0;
      equalto  <= 1'b0;
      zero     <= 1'b1;
    end else begin
      S        <= s_c;
      carry    <= carry_c;
      overflow <= ovf_c;
      lessthan <= lt_c;
      equalto  <= eq_c;
      zero     <= (s_c == '0);
    end
  end

endmodule

// File: tb/tb_alu_main.sv
// tb/tb_alu_main.sv - directed self-checking bench for alu_main
module tb_alu_main;

  logic        clk;
  logic        rst;
  logic [31:0] A;
  logic [31:0] B;
  logic [3:0]  control;
  logic [31:0] S;
  logic        carry;
  logic        overflow;
  logic        lessthan;
  logic        equalto;
  logic        zero;

  int n_cmp;
  int n_fail;

  alu_main dut (
    .clk      (clk),
    .rst      (rst),
    .A        (A),
    .B        (B),
    .control  (control),
    .S        (S),
    .carry    (carry),
    .overflow (overflow),
    .lessthan (lessthan),
    .equalto  (equalto),
    .zero     (zero)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] es, input logic ec,
                       input logic ev, input logic elt, input logic eeq, input logic ez);
    n_cmp++;
    assert (S === es) else begin
      n_fail++;
      $error("FAIL %s S: got %h want %h", tag, S, es);
    end
    n_cmp++;
    assert (carry === ec) else begin
      n_fail++;
      $error("FAIL %s carry: got %b want %b", tag, carry, ec);
    end
    n_cmp++;
    assert (overflow === ev) else begin
      n_fail++;
      $error("FAIL %s overflow: got %b want %b", tag, overflow, ev);
    end
    n_cmp++;
    assert (lessthan === elt) else begin
      n_fail++;
      $error("FAIL %s lessthan: got %b want %b", tag, lessthan, elt);
    end
    n_cmp++;
    assert (equalto === eeq) else begin
      n_fail++;
      $error("FAIL %s equalto: got %b want %b", tag, equalto, eeq);
    end
    n_cmp++;
    assert (zero === ez) else begin
      n_fail++;
      $error("FAIL %s zero: got %b want %b", tag, zero, ez);
    end
  endtask

  // Drive one operation, clock it, sample 1 time unit after the edge.
  task automatic step(input logic [31:0] a, input logic [31:0] b, input logic [3:0] op);
    A = a;
    B = b;
    control = op;
    @(posedge clk);
    #1;
  endtask

  initial begin
    n_cmp  = 0;
    n_fail = 0;
    rst = 1'b1;
    A = 32'd5;
    B = 32'd5;
    control = 4'd1;
    @(posedge clk);
    #1;
    check("reset", 32'h0, 0, 0, 0, 0, 1);
    rst = 1'b0;

    step(32'd5, 32'd5, 4'd1);
    check("sub_equal", 32'h0, 1, 0, 0, 1, 1);
    step(32'h8000_0000, 32'd2, 4'd1);
    check("sub_ovf", 32'h7FFF_FFFE, 1, 1, 1, 0, 0);
    step(32'd3, 32'd5, 4'd1);
    check("sub_borrow", 32'hFFFF_FFFE, 0, 0, 1, 0, 0);
    step(32'hFFFF_FFFF, 32'd1, 4'd0);
    check("add_wrap", 32'h0, 1, 0, 1, 0, 1);
    step(32'h7FFF_FFFF, 32'd1, 4'd0);
    check("add_ovf", 32'h8000_0000, 0, 1, 0, 0, 0);
    // Hold: inputs unchanged for another cycle.
    @(posedge clk);
    #1;
    check("hold", 32'h8000_0000, 0, 1, 0, 0, 0);

    step(32'hF0F0_F0F0, 32'hFF00_FF00, 4'd2);
    check("and", 32'hF000_F000, 0, 0, 1, 0, 0);
    step(32'hF0F0_F0F0, 32'hFF00_FF00, 4'd3);
    check("or", 32'hFFF0_FFF0, 0, 0, 1, 0, 0);
    step(32'hF0F0_F0F0, 32'hFF00_FF00, 4'd4);
    check("xor", 32'h0FF0_0FF0, 0, 0, 1, 0, 0);
    step(32'hF0F0_F0F0, 32'hFF00_FF00, 4'd5);
    check("nor", 32'h000F_000F, 0, 0, 1, 0, 0);

    step(32'h8000_0010, 32'd4, 4'd6);
    check("sll", 32'h0000_0100, 0, 0, 1, 0, 0);
    step(32'h8000_0010, 32'd4, 4'd7);
    check("srl", 32'h0800_0001, 0, 0, 1, 0, 0);
    step(32'h8000_0010, 32'd4, 4'd8);
    check("sra", 32'hF800_0001, 0, 0, 1, 0, 0);
    step(32'h8000_0010, 32'd4, 4'd9);
    check("slt", 32'h1, 0, 0, 1, 0, 0);
    step(32'h8000_0010, 32'd4, 4'd10);
    check("sltu", 32'h0, 0, 0, 1, 0, 1);
    step(32'h1234_5678, 32'd32, 4'd6);
    check("sll_by0", 32'h1234_5678, 0, 0, 0, 0, 0);
    step(32'h8000_0000, 32'h0000_0021, 4'd8);
    check("sra_by1", 32'hC000_0000, 0, 0, 1, 0, 0);

    step(32'd6, 32'd7, 4'd11);
`ifdef ALU_MUL_EN
    check("mul", 32'd42, 0, 0, 1, 0, 0);
`else
    check("mul_reserved", 32'h0, 0, 0, 1, 0, 1);
`endif
    step(32'd1, 32'd1, 4'd12);
    check("rsvd12", 32'h0, 0, 0, 0, 1, 1);
    step(32'hFFFF_FFFF, 32'hFFFF_FFFF, 4'd15);
    check("rsvd15", 32'h0, 0, 0, 0, 1, 1);

    // Reset mid-stream wins over live inputs, then the first free edge captures them.
    rst = 1'b1;
    step(32'd1, 32'd1, 4'd0);
    check("reset_mid", 32'h0, 0, 0, 0, 0, 1);
    rst = 1'b0;
    step(32'd1, 32'd1, 4'd0);
    check("after_reset", 32'd2, 0, 0, 0, 1, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
